pulse_seq_ctrl: RTL and testbench

//   Sequencer for the OSERDES pulse generator. Holds a table of pulse-train entries (width, count, gap, post-hold).

---
 rtl/pulse_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pulse_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_seq_ctrl.sv
// Pulse-train sequencer: replays a small table of generator configurations,
// handshaking each train through pg_start_o / pg_done_i, for a programmed number of passes.
module pulse_seq_ctrl #(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3,
    parameter int CLK_PER_US = 125
) (
    input  logic              clk_div,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [10:0]       cfg_width,
    input  logic [10:0]       cfg_num,
    input  logic [15:0]       cfg_gap,
    input  logic [15:0]       cfg_hold,
    input  logic [ADDR_W:0]   seq_len,
    input  logic [7:0]        loop_cnt,
    input  logic              run_i,
    input  logic              abort_i,
    output logic [10:0]       pg_width_o,
    output logic [10:0]       pg_num_o,
    output logic [15:0]       pg_gap_o,
    output logic              pg_start_o,
    input  logic              pg_done_i,
    output logic              busy_o,
    output logic              seq_done_o,
    output logic [ADDR_W-1:0] cur_idx_o,
    output logic              err_o,
    output logic [2:0]        fsm_state
);

    // Generator handshake: pg_start_o is a level held for two cycles with pg_*_o already
    // stable; the generator answers with a single-cycle pg_done_i once the train has finished.
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_HOLD, S_NEXT, S_DRAIN
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX  = (ADDR_W+1)'(DEPTH);
    localparam logic [6:0]      CYC_LAST = 7'(CLK_PER_US - 1);

    state_t            state;
    logic [53:0]       table_mem [DEPTH];
    logic [ADDR_W:0]   len_r;
    logic [7:0]        loop_r;
    logic [7:0]        pass_r;
    logic [ADDR_W-1:0] idx;
    logic [15:0]       hold_r;
    logic [6:0]        hold_cyc;
    logic [15:0]       hold_us;
    logic              start_ph;
    logic              pass_valid;

    logic [ADDR_W:0]   idx_inc;
    logic              wrap;
    logic [ADDR_W-1:0] idx_nxt;
    logic [7:0]        pass_inc;
    logic [53:0]       rd_entry;

    always_comb begin
        idx_inc  = {1'b0, idx} + 1'b1;
        wrap     = (idx_inc == len_r);
        idx_nxt  = wrap ? '0 : idx_inc[ADDR_W-1:0];
        pass_inc = (pass_r == 8'hFF) ? pass_r : pass_r + 8'd1;
        rd_entry = table_mem[(state == S_IDLE) ? '0 : idx_nxt];
    end

    // Table storage is deliberately outside reset so contents survive a sequencer reset.
    always_ff @(posedge clk_div) begin
        if (cfg_we && state == S_IDLE)
            table_mem[cfg_addr] <= {cfg_width, cfg_num, cfg_gap, cfg_hold};
    end

    always_ff @(posedge clk_div) begin
        if (rst) begin
            state      <= S_IDLE;
            pg_width_o <= '0;
            pg_num_o   <= '0;
            pg_gap_o   <= '0;
            pg_start_o <= 1'b0;
            seq_done_o <= 1'b0;
            err_o      <= 1'b0;
            len_r      <= '0;
            loop_r     <= '0;
            pass_r     <= '0;
            idx        <= '0;
            hold_r     <= '0;
            hold_cyc   <= '0;
            hold_us    <= '0;
            start_ph   <= 1'b0;
            pass_valid <= 1'b0;
        end else begin
            seq_done_o <= 1'b0;
            if (cfg_we && state != S_IDLE)
                err_o <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (run_i && !abort_i) begin
                        if (seq_len == '0 || seq_len > LEN_MAX) begin
                            err_o <= 1'b1;
                        end else begin
                            err_o      <= 1'b0;
                            len_r      <= seq_len;
                            loop_r     <= loop_cnt;
                            idx        <= '0;
                            pass_r     <= '0;
                            pass_valid <= 1'b0;
                            {pg_width_o, pg_num_o, pg_gap_o, hold_r} <= rd_entry;
                            state      <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort_i) begin
                        state <= S_IDLE;
                    end else if (pg_num_o == '0 || pg_gap_o == '0) begin
                        err_o <= 1'b1;
                        state <= S_NEXT;
                    end else begin
                        pass_valid <= 1'b1;
                        pg_start_o <= 1'b1;
                        start_ph   <= 1'b0;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (abort_i) begin
                        pg_start_o <= 1'b0;
                        state      <= S_IDLE;
                    end else if (!start_ph) begin
                        start_ph <= 1'b1;
                    end else begin
                        pg_start_o <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A done coinciding with abort means nothing is left to drain.
                    if (pg_done_i) begin
                        hold_cyc <= '0;
                        hold_us  <= '0;
                        if (abort_i)
                            state <= S_IDLE;
                        else
                            state <= (hold_r == '0) ? S_NEXT : S_HOLD;
                    end else if (abort_i) begin
                        state <= S_DRAIN;
                    end
                end
                S_HOLD: begin
                    if (abort_i) begin
                        state <= S_IDLE;
                    end else if (hold_cyc == CYC_LAST) begin
                        hold_cyc <= '0;
                        if (hold_us == hold_r - 16'd1)
                            state <= S_NEXT;
                        else
                            hold_us <= hold_us + 16'd1;
                    end else begin
                        hold_cyc <= hold_cyc + 7'd1;
                    end
                end
                S_NEXT: begin
                    if (abort_i) begin
                        state <= S_IDLE;
                    end else begin
                        idx <= idx_nxt;
                        if (wrap && (!pass_valid || (loop_r != '0 && pass_inc == loop_r))) begin
                            pass_r     <= pass_inc;
                            pass_valid <= 1'b0;
                            seq_done_o <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            if (wrap) begin
                                pass_r     <= pass_inc;
                                pass_valid <= 1'b0;
                            end
                            {pg_width_o, pg_num_o, pg_gap_o, hold_r} <= rd_entry;
                            state <= S_LOAD;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pg_done_i)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy_o    = (state != S_IDLE);
    assign cur_idx_o = idx;
    assign fsm_state = state;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Bench for pulse_seq_ctrl: a table model predicts every generator start (index, config,
// latency) into a queue; a negedge monitor plays the generator and checks each start.
module tb_pulse_seq_ctrl;
  localparam int W = 57;
  localparam logic [2:0] ST_WAIT = 3'd3, ST_HOLD = 3'd4, ST_DRAIN = 3'd6;

  logic clk_div = 1'b0, rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [10:0] cfg_width = '0, cfg_num = '0;
  logic [15:0] cfg_gap = '0, cfg_hold = '0;
  logic [3:0] seq_len = '0;
  logic [7:0] loop_cnt = '0;
  logic run_i = 1'b0, abort_i = 1'b0, pg_done_i = 1'b0;
  logic [10:0] pg_width_o, pg_num_o;
  logic [15:0] pg_gap_o;
  logic pg_start_o, busy_o, seq_done_o, err_o;
  logic [2:0] cur_idx_o, fsm_state;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, ref_cyc = 0, gen_delay = 4, done_cnt = 0, exp_done = 0;
  int tw[8], tn[8], tg[8], th[8];
  logic [W-1:0] exp_q[$];

  pulse_seq_ctrl dut (
    .clk_div(clk_div), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_width(cfg_width), .cfg_num(cfg_num), .cfg_gap(cfg_gap), .cfg_hold(cfg_hold),
    .seq_len(seq_len), .loop_cnt(loop_cnt), .run_i(run_i), .abort_i(abort_i),
    .pg_width_o(pg_width_o), .pg_num_o(pg_num_o), .pg_gap_o(pg_gap_o),
    .pg_start_o(pg_start_o), .pg_done_i(pg_done_i), .busy_o(busy_o),
    .seq_done_o(seq_done_o), .cur_idx_o(cur_idx_o), .err_o(err_o), .fsm_state(fsm_state)
  );

  // clock / reset
  always #4 clk_div = ~clk_div;
  initial forever begin
    @(posedge clk_div);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // generator model + start monitor
  initial begin
    logic start_prev = 1'b0;
    logic [37:0] prev_cfg = '0, rise_cfg = '0, cur_cfg;
    logic [W-1:0] item;
    int hi_cnt = 0, gen_cnt = 0;
    bit gen_arm = 0;
    forever begin
      @(negedge clk_div);
      pg_done_i = 1'b0;
      cur_cfg = {pg_width_o, pg_num_o, pg_gap_o};
      if (pg_start_o && !start_prev) begin
        check_eq("start_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          item = exp_q.pop_front();
          check_eq("start_delay", cyc - ref_cyc, item[56:41]);
          check_eq("start_idx", cur_idx_o, item[40:38]);
          check_eq("start_cfg", cur_cfg, item[37:0]);
          check_eq("cfg_setup", cur_cfg, prev_cfg);
        end
        rise_cfg = cur_cfg;
        hi_cnt = 1;
      end else if (pg_start_o) begin
        hi_cnt++;
      end else if (start_prev) begin
        check_eq("start_len", hi_cnt, 2);
        check_eq("cfg_stable", cur_cfg, rise_cfg);
        gen_cnt = gen_delay;
        gen_arm = 1;
      end
      if (gen_arm) begin
        if (gen_cnt == 0) begin
          pg_done_i = 1'b1;
          ref_cyc = cyc;
          gen_arm = 0;
        end else begin
          gen_cnt--;
        end
      end
      if (seq_done_o) done_cnt++;
      start_prev = pg_start_o;
      prev_cfg = cur_cfg;
    end
  end

  // driver tasks
  task automatic write_entry(input int a, input int w, input int n, input int g, input int h,
                             input bit update_model);
    cfg_we = 1'b1; cfg_addr = 3'(a);
    cfg_width = 11'(w); cfg_num = 11'(n); cfg_gap = 16'(g); cfg_hold = 16'(h);
    @(negedge clk_div);
    cfg_we = 1'b0;
    if (update_model) begin
      tw[a] = w; tn[a] = n; tg[a] = g; th[a] = h;
    end
  endtask

  task automatic pulse_run(input int sl, input int lc);
    seq_len = 4'(sl); loop_cnt = 8'(lc);
    run_i = 1'b1;
    ref_cyc = cyc;
    @(negedge clk_div);
    run_i = 1'b0;
  endtask

  task automatic pulse_abort();
    abort_i = 1'b1;
    @(negedge clk_div);
    abort_i = 1'b0;
  endtask

  // walk the table model: one queue entry per start, with latency from run or previous done
  task automatic expect_run(input int sl, input int lc);
    int base = 2;
    bit any;
    for (int p = 0; p < lc; p++) begin
      any = 0;
      for (int i = 0; i < sl; i++) begin
        if (tn[i] == 0 || tg[i] == 0) begin
          base += 2;
        end else begin
          exp_q.push_back({16'(base), 3'(i), 11'(tw[i]), 11'(tn[i]), 16'(tg[i])});
          base = 3 + th[i] * 125;
          any = 1;
        end
      end
      if (!any) break;
    end
    exp_done++;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy_o; i++) @(negedge clk_div);
    check_eq("idle_timeout", busy_o, 0);
    @(negedge clk_div);
  endtask

  task automatic run_and_wait(input int sl, input int lc);
    expect_run(sl, lc);
    pulse_run(sl, lc);
    wait_idle(20000);
    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("seq_done_cnt", done_cnt, exp_done);
  endtask

  initial begin
    repeat (3) @(negedge clk_div);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_start", pg_start_o, 0);
    check_eq("rst_cfg", {pg_width_o, pg_num_o, pg_gap_o}, 0);
    check_eq("rst_misc", {seq_done_o, err_o, cur_idx_o}, 0);
    rst = 1'b0;
    @(negedge clk_div);

    // single entry
    gen_delay = $urandom_range(2, 9);
    write_entry(0, 20, 3, 2, 0, 1);
    run_and_wait(1, 1);
    check_eq("single_err", err_o, 0);

    // multi-entry, two passes, 1 us hold after entry 0
    write_entry(0, 10, 2, 3, 1, 1);
    write_entry(1, 11, 4, 5, 0, 1);
    write_entry(2, 12, 1, 7, 0, 1);
    gen_delay = $urandom_range(2, 9);
    run_and_wait(3, 2);
    check_eq("multi_err", err_o, 0);
    check_eq("multi_idx_end", cur_idx_o, 0);

    // invalid entry skipped
    write_entry(1, 11, 0, 5, 0, 1);
    run_and_wait(3, 1);
    check_eq("invalid_err", err_o, 1);

    // whole pass invalid with loop_cnt=0 still terminates
    write_entry(0, 10, 2, 0, 0, 1);
    write_entry(1, 11, 0, 5, 0, 1);
    run_and_wait(2, 0);
    check_eq("allinv_err", err_o, 1);

    // abort in WAIT -> DRAIN until the generator finishes
    write_entry(0, 10, 2, 3, 0, 1);
    write_entry(1, 11, 4, 5, 0, 1);
    write_entry(2, 12, 1, 7, 0, 1);
    gen_delay = 20;
    exp_q.push_back({16'd2, 3'd0, 11'd10, 11'd2, 16'd3});
    pulse_run(3, 0);
    repeat (3) @(negedge clk_div);
    check_eq("abort_w_state", fsm_state, ST_WAIT);
    pulse_abort();
    check_eq("drain_state", fsm_state, ST_DRAIN);
    repeat (5) @(negedge clk_div);
    check_eq("drain_busy", busy_o, 1);
    wait_idle(100);
    check_eq("drain_no_done", done_cnt, exp_done);
    check_eq("drain_queue", exp_q.size(), 0);

    // abort in HOLD -> IDLE next cycle
    gen_delay = 3;
    write_entry(0, 10, 2, 3, 2, 1);
    exp_q.push_back({16'd2, 3'd0, 11'd10, 11'd2, 16'd3});
    pulse_run(1, 1);
    for (int i = 0; i < 200 && fsm_state != ST_HOLD; i++) @(negedge clk_div);
    check_eq("reach_hold", fsm_state, ST_HOLD);
    repeat ($urandom_range(5, 40)) @(negedge clk_div);
    check_eq("still_hold", fsm_state, ST_HOLD);
    pulse_abort();
    check_eq("hold_abort_busy", busy_o, 0);
    @(negedge clk_div);
    check_eq("hold_no_done", done_cnt, exp_done);

    // write while busy dropped, run while busy ignored
    write_entry(0, 30, 2, 4, 0, 1);
    gen_delay = 10;
    expect_run(1, 1);
    pulse_run(1, 1);
    repeat (4) @(negedge clk_div);
    write_entry(0, 99, 9, 9, 0, 0);
    run_i = 1'b1;
    @(negedge clk_div);
    run_i = 1'b0;
    wait_idle(200);
    check_eq("busy_write_err", err_o, 1);
    check_eq("busy_run_queue", exp_q.size(), 0);
    run_and_wait(1, 1);
    check_eq("run_clears_err", err_o, 0);

    // seq_len=0 rejected
    pulse_run(0, 1);
    repeat (8) @(negedge clk_div);
    check_eq("len0_busy", busy_o, 0);
    check_eq("len0_err", err_o, 1);

    // mid-run reset
    pulse_run(1, 1);
    check_eq("mid_busy_pre", busy_o, 1);
    rst = 1'b1;
    @(negedge clk_div);
    check_eq("mid_rst_busy", busy_o, 0);
    check_eq("mid_rst_start", pg_start_o, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk_div);
    check_eq("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
